hd_handshake_buffer: RTL and testbench

// - Valid/ready handshake stage between a producer (valid, data_src) and a consumer (ready, data_dest).
// - Registers accepted words and presents them in order on data_dest.
// - Back-pressures the producer via ready_output. Never drops or duplicates a word.
// - Sits on any point-to-point streaming link that needs a registered break.

---
 rtl/hd_handshake_buffer.sv | 99 +++++++++
 tb/tb_hd_handshake_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hd_handshake_buffer.sv
// Registered valid/ready stage: stores accepted words and presents them in FIFO order on data_dest.
// Latency: one cycle from accept to valid_output; data_dest is always driven from a register.
// Backpressure: ready_output drops when storage is full; HD_SKID_EN selects a 2-entry skid buffer with registered ready_output.
module hd_handshake_buffer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data_src,
  output logic                  ready_output,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data_dest,
  output logic                  valid_output
);

`ifdef HD_SKID_EN

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [1:0]            r_count;
  logic                  r_rdy;
  logic                  w_accept;
  logic                  w_drain;
  logic [1:0]            w_count_nxt;

  // ready_output is a flop so the producer never sees a combinational path from the consumer's ready.
  assign ready_output = r_rdy;
  assign valid_output = (r_count != 2'd0);
  assign data_dest    = r_head;
  assign w_accept     = valid && r_rdy;
  assign w_drain      = (r_count != 2'd0) && ready;

  // Occupancy after this cycle's accept/drain; accept cannot happen at count 2.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_accept, w_drain})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Head/skid data movement and occupancy; reset discards everything stored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_skid  <= '0;
      r_count <= 2'd0;
      r_rdy   <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_rdy   <= (w_count_nxt != 2'd2);
      case (r_count)
        2'd0: begin
          if (w_accept) r_head <= data_src;
        end
        2'd1: begin
          // Head leaving while a new word arrives: new word becomes head directly.
          if (w_accept && w_drain) r_head <= data_src;
          else if (w_accept)       r_skid <= data_src;
        end
        default: begin
          if (w_drain) r_head <= r_skid;
        end
      endcase
    end
  end

`else

  logic [DATA_WIDTH-1:0] r_head;
  logic                  r_vld;
  logic                  w_accept;
  logic                  w_drain;

  // Single entry: we can take a new word whenever the head is empty or leaving this cycle.
  assign ready_output = !r_vld || ready;
  assign valid_output = r_vld;
  assign data_dest    = r_head;
  assign w_accept     = valid && ready_output;
  assign w_drain      = r_vld && ready;

  // Head register: refill on accept (also covers accept+drain), clear valid on drain only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head <= '0;
      r_vld  <= 1'b0;
    end else if (w_accept) begin
      r_head <= data_src;
      r_vld  <= 1'b1;
    end else if (w_drain) begin
      r_vld  <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_hd_handshake_buffer.sv
// Self-checking bench for hd_handshake_buffer (either build, HD_SKID_EN defined or not).
// Expected outputs per vector come from a queue-based reference model run over the table up front.
// A scoreboard also tracks accepted words and checks every delivered word in order.
module tb_hd_handshake_buffer;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [15:0] data_src;
  logic        ready_output;
  logic        ready;
  logic [15:0] data_dest;
  logic        valid_output;

  int n_vec;
  int n_err;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        ready;
    logic        exp_vo;
    logic        exp_ro;
    logic [15:0] exp_dd;
  } vec_t;

  vec_t        vq[$];
  logic [15:0] sb[$];
  logic [15:0] next_data;

  hd_handshake_buffer #(.DATA_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid),
    .data_src     (data_src),
    .ready_output (ready_output),
    .ready        (ready),
    .data_dest    (data_dest),
    .valid_output (valid_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic rd);
    vec_t e;
    e.rst = r; e.valid = v; e.ready = rd;
    e.exp_vo = 1'b0; e.exp_ro = 1'b0; e.exp_dd = '0;
    vq.push_back(e);
  endtask

  // Reference model: storage as a queue with capacity 1 (default) or 2 (skid).
  task automatic build_expected();
    logic [15:0] mq[$];
    logic [15:0] mlast;
    logic [15:0] mnext;
    logic        acc;
    logic        dr;
    mlast = '0;
    mnext = 16'd1;
    for (int i = 0; i < vq.size(); i++) begin
      vq[i].exp_vo = (mq.size() != 0);
      vq[i].exp_dd = (mq.size() != 0) ? mq[0] : mlast;
`ifdef HD_SKID_EN
      vq[i].exp_ro = (mq.size() != 2);
`else
      vq[i].exp_ro = (mq.size() == 0) || vq[i].ready;
`endif
      if (!vq[i].rst) begin
        mq.delete();
        mlast = '0;
      end else begin
        acc = vq[i].valid && vq[i].exp_ro;
        dr  = vq[i].exp_vo && vq[i].ready;
        if (dr) mlast = mq.pop_front();
        if (acc) begin
          mq.push_back(mnext);
          mnext++;
        end
      end
    end
  endtask

  // Drive one cycle at the negedge, check settled outputs, update scoreboard from observed handshakes.
  task automatic apply(input int i);
    logic [15:0] exp_w;
    rst   = vq[i].rst;
    valid = vq[i].valid;
    ready = vq[i].ready;
    data_src = vq[i].valid ? next_data : 16'($urandom);
    #1;
    chk($sformatf("v%0d valid_output", i), {15'd0, valid_output}, {15'd0, vq[i].exp_vo});
    chk($sformatf("v%0d ready_output", i), {15'd0, ready_output}, {15'd0, vq[i].exp_ro});
    chk($sformatf("v%0d data_dest", i), data_dest, vq[i].exp_dd);
    if (!rst) begin
      sb.delete();
    end else begin
      if (valid_output && ready) begin
        if (sb.size() == 0) begin
          chk($sformatf("v%0d drain with empty scoreboard", i), 16'd1, 16'd0);
        end else begin
          exp_w = sb.pop_front();
          chk($sformatf("v%0d delivered word", i), data_dest, exp_w);
        end
      end
      if (valid && ready_output) begin
        sb.push_back(data_src);
        next_data++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] held;
    n_vec = 0;
    n_err = 0;
    next_data = 16'd1;
    rst = 1'b0; valid = 1'b0; ready = 1'b0; data_src = '0;

    // Stimulus table: {rst, valid, ready}
    add(1, 0, 0);                                  // post-reset idle
    for (int k = 0; k < 3; k++) add(1, 1, 0);      // fill while consumer stalls
    add(1, 1, 1);                                  // single ready pulse
    for (int k = 0; k < 2; k++) add(1, 1, 0);
    for (int k = 0; k < 4; k++) add(1, 1, 1);      // streaming
    for (int k = 0; k < 6; k++) add(1, 1, k[0] ? 1'b0 : 1'b1); // alternating ready
    for (int k = 0; k < 4; k++) add(1, 0, 1);      // drain to empty
    add(1, 1, 1);                                  // restart after empty
    add(1, 0, 0);
    add(1, 1, 0);
    add(1, 1, 0);
    add(0, 0, 0);                                  // reset while holding words
    add(1, 0, 1);
    add(1, 0, 1);
    build_expected();

    // Initial reset (unchecked: outputs are unknown before the first reset edge)
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < vq.size(); i++) apply(i);
    chk("scoreboard empty after reset", 16'(sb.size()), 16'd0);

    // Hand-written: stalled head ignores valid=0 and changing data_src, then drains and holds.
    held = 16'hA5A5;
    rst = 1'b1; valid = 1'b1; ready = 1'b0; data_src = held;
    #1;
    chk("hs ready_output empty", {15'd0, ready_output}, 16'd1);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      valid = 1'b0; ready = 1'b0; data_src = 16'($urandom);
      #1;
      chk($sformatf("hs stall%0d valid_output", k), {15'd0, valid_output}, 16'd1);
      chk($sformatf("hs stall%0d data_dest", k), data_dest, held);
      @(posedge clk);
      @(negedge clk);
    end
    valid = 1'b0; ready = 1'b1; data_src = 16'h1234;
    #1;
    chk("hs drain data_dest", data_dest, held);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("hs empty valid_output", {15'd0, valid_output}, 16'd0);
    chk("hs empty holds last", data_dest, held);
    chk("hs empty ready_output", {15'd0, ready_output}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
